rx_glitch_filter: RTL and testbench



---
 rtl/rx_filter_pkg.sv | 28 ++
 rtl/rx_filter_chk.sv | 16 +
 rtl/rx_filter_lane.sv | 114 +++++++++++
 rtl/rx_glitch_filter.sv | 44 ++++
 tb/tb_rx_glitch_filter.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/rx_filter_pkg.sv
// Shared types and helpers for the receive-line glitch filter.
package rx_filter_pkg;

    typedef enum logic {
        FILT_UNANIMOUS = 1'b0,
        FILT_MAJORITY  = 1'b1
    } filt_mode_e;

    // Widest window the popcount helper supports, and its count width.
    localparam int unsigned POP_MAX_W = 64;
    localparam int unsigned POP_CNT_W = 7;

    // Counts set bits among the low 'width' bits of vec; callers truncate to their own count width.
    function automatic logic [POP_CNT_W-1:0] popcount(
        input logic [POP_MAX_W-1:0] vec,
        input int unsigned          width
    );
        logic [POP_CNT_W-1:0] cnt;
        cnt = {POP_CNT_W{1'b0}};
        for (int unsigned i = 0; i < POP_MAX_W; i++) begin
            if (i < width) begin
                cnt = cnt + {{(POP_CNT_W-1){1'b0}}, vec[i]};
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rx_filter_chk.sv
// Run-time checks for the glitch filter configuration.
module rx_filter_chk #(
    parameter int DEPTH = 3
) (
    input logic i_clk,
    input logic i_rst,
    input logic i_mode
);

    // An even window has no majority, so majority mode is only legal with odd DEPTH.
    a_even_depth_majority: assert property (
        @(posedge i_clk) disable iff (i_rst)
        !(i_mode && ((DEPTH % 32'sd2) == 32'sd0))
    );

endmodule

// File: rtl/rx_filter_lane.sv
// One filter lane: sync chain, sample window, decision and registered outputs.
// Edge pulse registers exist only when RX_FILTER_EDGE_EN is defined.
module rx_filter_lane
    import rx_filter_pkg::*;
#(
    parameter int   DEPTH       = 3,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rxc,
    input  logic i_mode,
    input  logic i_rxd,
    output logic o_rxd,
    output logic o_rise,
    output logic o_fall
);

    localparam int POP_W = $clog2(DEPTH + 32'sd1);
    localparam logic [POP_W-1:0] HALF = POP_W'(DEPTH / 32'sd2);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [DEPTH-1:0]       r_win;
    logic                   r_out;
    logic                   w_sample;
    logic                   w_next;
    logic [POP_W-1:0]       w_pop;

    assign w_sample = r_sync[SYNC_STAGES-1];
    assign w_pop    = POP_W'(popcount(POP_MAX_W'(r_win), DEPTH));

    // Metastability chain, clocked every cycle regardless of the strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            r_sync[0] <= i_rxd;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    // Sample window advances only on the strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_win <= {DEPTH{RESET_LEVEL}};
        end else if (i_rxc) begin
            r_win[0] <= w_sample;
            for (int k = 1; k < DEPTH; k++) begin
                r_win[k] <= r_win[k-1];
            end
        end else begin
            r_win <= r_win;
        end
    end

    // Decision rule; unanimous mode holds the last level on a mixed window.
    always_comb begin
        w_next = r_out;
        case (filt_mode_e'(i_mode))
            FILT_UNANIMOUS: begin
                if (&r_win) begin
                    w_next = 1'b1;
                end else if (~|r_win) begin
                    w_next = 1'b0;
                end else begin
                    w_next = r_out;
                end
            end
            FILT_MAJORITY: begin
                w_next = (w_pop > HALF);
            end
            default: begin
                w_next = r_out;
            end
        endcase
    end

    // Filtered level register, updated every cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out <= RESET_LEVEL;
        end else begin
            r_out <= w_next;
        end
    end

    assign o_rxd = r_out;

`ifdef RX_FILTER_EDGE_EN
    logic r_rise;
    logic r_fall;

    // Edge pulses coincide with the cycle the filtered level changes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_next & ~r_out;
            r_fall <= ~w_next & r_out;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;
`else
    assign o_rise = 1'b0;
    assign o_fall = 1'b0;
`endif

endmodule

// File: rtl/rx_glitch_filter.sv
// Multi-channel receive-line glitch filter: one independent lane per channel.
// Define RX_FILTER_EDGE_EN to build the RISE/FALL pulse logic; otherwise they read 0.
module rx_glitch_filter #(
    parameter int   CHANNELS    = 1,
    parameter int   DEPTH       = 3,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                RXC,
    input  logic                MODE,
    input  logic [CHANNELS-1:0] RXD_IN,
    output logic [CHANNELS-1:0] RXD_OUT,
    output logic [CHANNELS-1:0] RISE,
    output logic [CHANNELS-1:0] FALL
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        rx_filter_lane #(
            .DEPTH       (DEPTH),
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_lane (
            .i_clk  (CLK),
            .i_rst  (RST),
            .i_rxc  (RXC),
            .i_mode (MODE),
            .i_rxd  (RXD_IN[g]),
            .o_rxd  (RXD_OUT[g]),
            .o_rise (RISE[g]),
            .o_fall (FALL[g])
        );
    end

    rx_filter_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .i_clk  (CLK),
        .i_rst  (RST),
        .i_mode (MODE)
    );

endmodule

// File: tb/tb_rx_glitch_filter.sv
// Directed self-checking bench: a 4-lane DEPTH=3 instance and a 1-lane DEPTH=5 instance.
module tb_rx_glitch_filter;

`ifdef RX_FILTER_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rxc;
    logic       mode;
    logic [3:0] a_in;
    logic [3:0] a_out;
    logic [3:0] a_rise;
    logic [3:0] a_fall;
    logic       b_in;
    logic       b_out;
    logic       b_rise;
    logic       b_fall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rx_glitch_filter #(
        .CHANNELS(4), .DEPTH(3), .SYNC_STAGES(2), .RESET_LEVEL(1'b1)
    ) u_dut_a (
        .CLK(clk), .RST(rst), .RXC(rxc), .MODE(mode),
        .RXD_IN(a_in), .RXD_OUT(a_out), .RISE(a_rise), .FALL(a_fall)
    );

    rx_glitch_filter #(
        .CHANNELS(1), .DEPTH(5), .SYNC_STAGES(2), .RESET_LEVEL(1'b1)
    ) u_dut_b (
        .CLK(clk), .RST(rst), .RXC(rxc), .MODE(mode),
        .RXD_IN(b_in), .RXD_OUT(b_out), .RISE(b_rise), .FALL(b_fall)
    );

    task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int sel, input logic [3:0] v);
        if (sel == 0) a_in = v;
        else          b_in = v[0];
    endtask

    // Drives pulse_in for 'width' edges then base_in; output expected to move to new_out
    // at edge lat and back to old_out at edge lat2 (0 = never).
    task automatic pulse_check(input string tag, input int sel,
                               input logic [3:0] pulse_in, input logic [3:0] base_in,
                               input int width, input int total, input int lat, input int lat2,
                               input logic [3:0] old_out, input logic [3:0] new_out);
        logic [3:0] exp_out;
        logic [3:0] prev;
        logic [3:0] got_out;
        logic [3:0] got_rise;
        logic [3:0] got_fall;
        prev = old_out;
        set_in(sel, pulse_in);
        for (int e = 1; e <= total; e++) begin
            tick();
            if (e == width) set_in(sel, base_in);
            exp_out = (lat != 0 && e >= lat && (lat2 == 0 || e < lat2)) ? new_out : old_out;
            got_out  = (sel == 0) ? a_out  : {3'b000, b_out};
            got_rise = (sel == 0) ? a_rise : {3'b000, b_rise};
            got_fall = (sel == 0) ? a_fall : {3'b000, b_fall};
            check_eq($sformatf("%s_out_e%0d", tag, e), got_out, exp_out);
            check_eq($sformatf("%s_rise_e%0d", tag, e), got_rise, EDGE_EN ? (exp_out & ~prev) : 4'h0);
            check_eq($sformatf("%s_fall_e%0d", tag, e), got_fall, EDGE_EN ? (~exp_out & prev) : 4'h0);
            prev = exp_out;
        end
    endtask

    initial begin
        logic [3:0] exp_o;
        logic [3:0] exp_f;

        rst = 1'b1; rxc = 1'b1; mode = 1'b0; a_in = 4'hF; b_in = 1'b1;
        repeat (3) tick();
        check_eq("rst_a_out", a_out, 4'hF);
        check_eq("rst_a_rise", a_rise, 4'h0);
        check_eq("rst_a_fall", a_fall, 4'h0);
        check_eq("rst_b_out", {3'b000, b_out}, 4'h1);
        rst = 1'b0;
        pulse_check("release", 0, 4'hF, 4'hF, 8, 8, 0, 0, 4'hF, 4'hF);

        // Unanimous mode, DEPTH=3: step latency 6, glitch rejection below 3 strobes.
        pulse_check("u_fall", 0, 4'hE, 4'hE, 8, 8, 6, 0, 4'hF, 4'hE);
        pulse_check("u_rise", 0, 4'hF, 4'hF, 8, 8, 6, 0, 4'hE, 4'hF);
        pulse_check("u_gl2", 0, 4'hE, 4'hF, 2, 10, 0, 0, 4'hF, 4'hF);
        pulse_check("u_gl3", 0, 4'hE, 4'hF, 3, 12, 6, 9, 4'hF, 4'hE);

        // Majority mode, DEPTH=3: step latency 5.
        mode = 1'b1;
        pulse_check("m_fall", 0, 4'hD, 4'hD, 7, 7, 5, 0, 4'hF, 4'hD);
        pulse_check("m_rise", 0, 4'hF, 4'hF, 7, 7, 5, 0, 4'hD, 4'hF);
        pulse_check("m_gl1", 0, 4'hD, 4'hF, 1, 8, 0, 0, 4'hF, 4'hF);
        pulse_check("m_gl2", 0, 4'hD, 4'hF, 2, 10, 5, 7, 4'hF, 4'hD);

        // Majority mode, DEPTH=5.
        pulse_check("b_gl2", 1, 4'h0, 4'h1, 2, 10, 0, 0, 4'h1, 4'h1);
        pulse_check("b_gl3", 1, 4'h0, 4'h1, 3, 12, 6, 9, 4'h1, 4'h0);
        pulse_check("b_step", 1, 4'h0, 4'h0, 7, 7, 6, 0, 4'h1, 4'h0);
        pulse_check("b_back", 1, 4'h1, 4'h1, 7, 7, 6, 0, 4'h0, 4'h1);

        // Sparse strobe 1-in-16 on lane 2, unanimous mode.
        mode = 1'b0;
        a_in = 4'hB;
        rxc  = 1'b0;
        for (int e = 1; e <= 52; e++) begin
            tick();
            exp_o = (e >= 49) ? 4'hB : 4'hF;
            exp_f = (EDGE_EN && e == 49) ? 4'h4 : 4'h0;
            check_eq($sformatf("sparse_out_e%0d", e), a_out, exp_o);
            check_eq($sformatf("sparse_fall_e%0d", e), a_fall, exp_f);
            rxc = (((e + 1) % 16) == 0);
        end
        rxc = 1'b0;
        pulse_check("frozen", 0, 4'hF, 4'hF, 20, 20, 0, 0, 4'hB, 4'hB);
        rxc = 1'b1;
        pulse_check("thaw", 0, 4'hF, 4'hF, 5, 5, 4, 0, 4'hB, 4'hF);

        // Lanes 3 and 0 step at different times.
        a_in = 4'h7;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 2) a_in = 4'h6;
            exp_o = {(e >= 6) ? 1'b0 : 1'b1, 2'b11, (e >= 8) ? 1'b0 : 1'b1};
            exp_f = EDGE_EN ? {(e == 6), 2'b00, (e == 8)} : 4'h0;
            check_eq($sformatf("indep_out_e%0d", e), a_out, exp_o);
            check_eq($sformatf("indep_fall_e%0d", e), a_fall, exp_f);
        end
        pulse_check("indep_back", 0, 4'hF, 4'hF, 7, 7, 6, 0, 4'h6, 4'hF);

        // Reset asserted mid-traffic while lane 1 is low.
        a_in = 4'hD;
        repeat (7) tick();
        check_eq("pre_rst_out", a_out, 4'hD);
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_rst_out", a_out, 4'hF);
        check_eq("async_rst_rise", a_rise, 4'h0);
        check_eq("async_rst_fall", a_fall, 4'h0);
        a_in = 4'hF;
        repeat (2) tick();
        rst = 1'b0;
        pulse_check("post_rst", 0, 4'hF, 4'hF, 8, 8, 0, 0, 4'hF, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
